sobel_filter: RTL and testbench

Streaming 3x3 Sobel edge detector that sits directly upstream of the grayscale-to-RGB stage. It consumes a raster-order 8-bit grayscale pixel stream qualified by `done_i`. It buffers two image lines to form a sliding 3x3 window and emits the saturated gradient magnitude |Gx|+|Gy| as an 8-bit grayscale stream qualified by `done_o`, which feeds the grayscale-to-RGB stage's `grayscale_i`/`done_i` directly.

---
 rtl/sobel_pkg.sv | 32 +++
 rtl/sobel_filter_line_buffer.sv | 23 ++
 rtl/sobel_filter.sv | 147 ++++++++++++++
 tb/tb_sobel_filter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types, kernel coefficients and helpers for the streaming Sobel edge detector.
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0]        mag_t;

  // Row 0 is the oldest line, column 0 the oldest column.
  localparam int KX [3][3] = '{
    '{-1, 0, 1},
    '{-2, 0, 2},
    '{-1, 0, 1}
  };

  localparam int KY [3][3] = '{
    '{-1, -2, -1},
    '{ 0,  0,  0},
    '{ 1,  2,  1}
  };

  function automatic mag_t abs_g(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

  function automatic pix_t sat8(input mag_t m);
    return (m > mag_t'(255)) ? pix_t'(8'hFF) : m[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_filter_line_buffer.sv
// One image line of storage; read returns the old word while the same
// address is overwritten on the clock edge.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a sliding window
// and a three-stage gradient/magnitude pipeline.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_i,
  input  logic             done_i,
  output logic [PIX_W-1:0] grayscale_o,
  output logic             done_o,
  output logic             frame_end_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  pix_t lb0_rd, lb1_rd;
  pix_t win_q [3][3];

  logic  gate, last;
  logic  v1_q, fe1_q;
  logic  v2_q, fe2_q;
  grad_t gx_q, gy_q, gx_d, gy_d;
  pix_t  gray_q, gray_d;
  logic  done_q, fe3_q;

  assign last = (col_q == CW'(IMG_WIDTH - 1)) &&
                (row_q == RW'(IMG_HEIGHT - 1));
  assign gate = (col_q >= CW'(2)) && (row_q >= RW'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (done_i) begin
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_HEIGHT - 1)) row_d = '0;
        else                              row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .we_i    (done_i),
    .addr_i  (col_q),
    .wdata_i (pixel_i),
    .rdata_o (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .we_i    (done_i),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Stage 1: counters, window shift and output gate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      v1_q  <= 1'b0;
      fe1_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v1_q  <= done_i & gate;
      fe1_q <= done_i & gate & last;
      if (done_i) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_rd;
        win_q[1][2] <= lb0_rd;
        win_q[2][2] <= pixel_i;
      end
    end
  end

  always_comb begin
    gx_d = '0;
    gy_d = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        gx_d = gx_d + grad_t'(KX[r][c]) *
               grad_t'({{(GRAD_W-PIX_W){1'b0}}, win_q[r][c]});
        gy_d = gy_d + grad_t'(KY[r][c]) *
               grad_t'({{(GRAD_W-PIX_W){1'b0}}, win_q[r][c]});
      end
    end
  end

  // Stage 2: gradients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_q  <= '0;
      gy_q  <= '0;
      v2_q  <= 1'b0;
      fe2_q <= 1'b0;
    end else begin
      v2_q  <= v1_q;
      fe2_q <= fe1_q;
      if (v1_q) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
    end
  end

  always_comb begin
    gray_d = gray_q;
    if (v2_q) gray_d = sat8(abs_g(gx_q) + abs_g(gy_q));
  end

  // Stage 3: saturated magnitude; value holds between valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q <= '0;
      done_q <= 1'b0;
      fe3_q  <= 1'b0;
    end else begin
      gray_q <= gray_d;
      done_q <= v2_q;
      fe3_q  <= fe2_q;
    end
  end

  assign grayscale_o = gray_q;
  assign done_o      = done_q;
  assign frame_end_o = fe3_q;

endmodule

// File: tb/tb_sobel_filter.sv
// Scoreboard bench for sobel_filter on a 4x4 image: a reference
// convolution predicts each output, popped when done_o fires.
module tb_sobel_filter;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    int v;
    int fe;
    int acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixel_i;
  logic       done_i;
  logic [7:0] grayscale_o;
  logic       done_o;
  logic       frame_end_o;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   fe_cnt = 0;
  int   img [H][W];
  exp_t q [$];

  int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  sobel_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_i     (pixel_i),
    .done_i      (done_i),
    .grayscale_o (grayscale_o),
    .done_o      (done_o),
    .frame_end_o (frame_end_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: full-window convolution on the stored image.
  function automatic int ref_mag(input int r, input int c);
    int gx = 0, gy = 0, m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        gx += kx[i][j] * img[r-2+i][c-2+j];
        gy += ky[i][j] * img[r-2+i][c-2+j];
      end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic load(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 77;
          1:       img[r][c] = (c >= 2) ? 10 : 0;
          2:       img[r][c] = (r >= 2) ? 10 : 0;
          default: img[r][c] = (r == 1 && c == 1) ? 200 : 0;
        endcase
  endtask

  task automatic run_frame(input int kind, input bit stall, input int npix);
    exp_t e;
    int n = 0;
    load(kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          if (stall && n != 0) begin
            done_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          pixel_i = 8'(img[r][c]);
          done_i  = 1'b1;
          @(posedge clk);
          #1;
          if (r >= 2 && c >= 2) begin
            e.v   = ref_mag(r, c);
            e.fe  = (r == H-1 && c == W-1) ? 1 : 0;
            e.acc = cyc;
            q.push_back(e);
          end
          n++;
        end
      end
    done_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int d0, input int f0,
                       input int nd, input int nf);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_q_empty"}, q.size(), 0);
    chk({tag, "_done_cnt"}, done_cnt - d0, nd);
    chk({tag, "_fe_cnt"}, fe_cnt - f0, nf);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done_o) begin
        done_cnt++;
        if (frame_end_o) fe_cnt++;
        chk("out_expected", (q.size() != 0) ? 1 : 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("gray", grayscale_o, e.v);
          chk("frame_end", frame_end_o, e.fe);
          chk("latency", cyc - e.acc, 2);
        end
      end else if (frame_end_o) begin
        chk("fe_without_done", frame_end_o, 0);
      end
    end
  end

  initial begin
    int d0, f0;
    rst     = 1'b1;
    pixel_i = '0;
    done_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gray", grayscale_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_fe", frame_end_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    d0 = done_cnt; f0 = fe_cnt;
    run_frame(0, 1'b0, 16);
    drain("const", d0, f0, 4, 1);

    d0 = done_cnt; f0 = fe_cnt;
    run_frame(1, 1'b0, 16);
    drain("vert", d0, f0, 4, 1);

    d0 = done_cnt; f0 = fe_cnt;
    run_frame(2, 1'b0, 16);
    drain("horiz", d0, f0, 4, 1);
    chk("hold_gray", grayscale_o, 40);

    run_frame(1, 1'b0, 9);
    rst = 1'b1;
    #1;
    chk("mid_rst_gray", grayscale_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_fe", frame_end_o, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt; f0 = fe_cnt;
    run_frame(1, 1'b0, 16);
    drain("post_rst", d0, f0, 4, 1);

    d0 = done_cnt; f0 = fe_cnt;
    run_frame(3, 1'b0, 16);
    drain("impulse", d0, f0, 4, 1);

    d0 = done_cnt; f0 = fe_cnt;
    run_frame(3, 1'b1, 16);
    run_frame(0, 1'b0, 16);
    drain("stall_b2b", d0, f0, 8, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
